// File: rtl/dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : dma_responder
// Purpose  : Responder side of the controller-to-DMA command handshake for
//            the inverted-residual-block accelerator. Accepts one command at
//            a time and either loads external memory into an on-chip buffer
//            (layer info word, FMI tile, KEX/KPW/KDW kernels) or stores the
//            output buffer to external memory (FMO tile). Completion is a
//            single-cycle f_dma pulse.
// Ports    : clk, rst                      - clock, sync active-high reset
//            s_dma, dma_op, dma_info*,
//            dma_mem_info*                  - command from controller
//            f_dma, busy, err_op, err_busy  - status
//            inf_conv, tag_info1/2          - latched layer info / loop tags
//            mem_*                          - external memory request port
//            buf_*                          - on-chip buffer port
//            perf_rd_cycles, perf_wr_cycles - busy-cycle counters
// Options  : DMA_PERF_CNT_EN - when defined, perf_* count cycles spent in the
//            read / write burst states; otherwise they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dma_responder #(
    parameter int          DATA_W    = 32,
    parameter int          BUF_AW    = 12,
    parameter int          MAX_OUTST = 4,
    parameter logic [31:0] INF_BASE  = 32'h0000_0000,
    parameter logic [31:0] FMI_BASE  = 32'h0001_0000,
    parameter logic [31:0] KEX_BASE  = 32'h0010_0000,
    parameter logic [31:0] KPW_BASE  = 32'h0020_0000,
    parameter logic [31:0] KDW_BASE  = 32'h0030_0000,
    parameter logic [31:0] FMO_BASE  = 32'h0040_0000,
    parameter int          LEN_FMI   = 256,
    parameter int          LEN_KEX   = 64,
    parameter int          LEN_KPW   = 64,
    parameter int          LEN_KDW   = 72,
    parameter int          LEN_FMO   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_dma,
    input  logic [2:0]        dma_op,
    input  logic [31:0]       dma_info1,
    input  logic [31:0]       dma_info2,
    input  logic [31:0]       dma_mem_info1,
    input  logic [31:0]       dma_mem_info2,
    output logic              f_dma,
    output logic              busy,
    output logic [63:0]       inf_conv,
    output logic [31:0]       tag_info1,
    output logic [31:0]       tag_info2,
    output logic              err_op,
    output logic              err_busy,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        buf_sel,
    output logic              buf_we,
    output logic              buf_re,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic [63:0]       perf_rd_cycles,
    output logic [63:0]       perf_wr_cycles
);

    // Counters are one bit wider than the buffer address so a full
    // 2^BUF_AW burst length is representable.
    localparam int              c_cw        = BUF_AW + 1;
    localparam int              c_pad       = 32 - c_cw;
    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_len_inf   = c_cw'(2);
    localparam logic [c_cw-1:0] c_len_fmi   = c_cw'(LEN_FMI);
    localparam logic [c_cw-1:0] c_len_kex   = c_cw'(LEN_KEX);
    localparam logic [c_cw-1:0] c_len_kpw   = c_cw'(LEN_KPW);
    localparam logic [c_cw-1:0] c_len_kdw   = c_cw'(LEN_KDW);
    localparam logic [c_cw-1:0] c_len_fmo   = c_cw'(LEN_FMO);
    localparam logic [3:0]      c_max_outst = 4'(MAX_OUTST);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [31:0]       r_start;
    logic [c_cw-1:0]   r_len;
    logic [c_cw-1:0]   r_issued;
    logic [c_cw-1:0]   r_received;
    logic [3:0]        r_outst;
    logic [c_cw-1:0]   r_k;
    logic [c_cw-1:0]   r_sent;
    logic              r_rd_pend;
    logic              r_stg_valid;
    logic [DATA_W-1:0] r_stg_data;
    logic [63:0]       r_inf_conv;
    logic [31:0]       r_tag1;
    logic [31:0]       r_tag2;
    logic              r_err_op;
    logic              r_err_busy;

    logic [31:0]       w_base;
    logic [c_cw-1:0]   w_len;
    logic [31:0]       w_start;
    logic              w_in_rd;
    logic              w_in_wr;
    logic              w_rd_req;
    logic              w_rd_gnt;
    logic              w_rd_rcv;
    logic              w_have;
    logic [DATA_W-1:0] w_wdata;
    logic              w_wr_req;
    logic              w_wr_fire;
    logic              w_buf_re;

    always_comb begin
        w_base = INF_BASE;
        w_len  = c_len_inf;
        case (dma_op)
            3'd1:    begin w_base = FMI_BASE; w_len = c_len_fmi; end
            3'd2:    begin w_base = KEX_BASE; w_len = c_len_kex; end
            3'd3:    begin w_base = KPW_BASE; w_len = c_len_kpw; end
            3'd4:    begin w_base = KDW_BASE; w_len = c_len_kdw; end
            3'd5:    begin w_base = FMO_BASE; w_len = c_len_fmo; end
            default: ;
        endcase
    end

    // The layer info word lives at a fixed address; offsets do not apply.
    assign w_start = (dma_op == 3'd0) ? INF_BASE
                                      : (w_base + dma_mem_info1 + dma_mem_info2);

    assign w_in_rd  = (r_state == c_st_rd);
    assign w_in_wr  = (r_state == c_st_wr);
    assign w_rd_req = w_in_rd && (r_issued < r_len) && (r_outst < c_max_outst);
    assign w_rd_gnt = w_rd_req && mem_gnt;
    // Read data arriving outside a read burst (e.g. after an abort) is dropped.
    assign w_rd_rcv = w_in_rd && mem_rvalid;

    // Write staging: the word read from the buffer last cycle is presented
    // straight from buf_rdata; if it is not granted it is captured in
    // r_stg_data. A new buffer read is only launched when the slot will be
    // free next cycle, so a word is never overwritten before it is sent and
    // back-to-back grants still move one word per cycle.
    assign w_have    = r_rd_pend || r_stg_valid;
    assign w_wdata   = r_rd_pend ? buf_rdata : r_stg_data;
    assign w_wr_req  = w_in_wr && w_have;
    assign w_wr_fire = w_wr_req && mem_gnt;
    assign w_buf_re  = w_in_wr && (r_k < r_len) && (!w_have || w_wr_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_op        <= '0;
            r_start     <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_outst     <= '0;
            r_k         <= '0;
            r_sent      <= '0;
            r_rd_pend   <= 1'b0;
            r_stg_valid <= 1'b0;
            r_stg_data  <= '0;
            r_inf_conv  <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_err_op    <= 1'b0;
            r_err_busy  <= 1'b0;
        end else begin
            if (s_dma && (r_state != c_st_idle)) begin
                r_err_busy <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (s_dma) begin
                        r_op        <= dma_op;
                        r_tag1      <= dma_info1;
                        r_tag2      <= dma_info2;
                        r_start     <= w_start;
                        r_len       <= w_len;
                        r_issued    <= '0;
                        r_received  <= '0;
                        r_outst     <= '0;
                        r_k         <= '0;
                        r_sent      <= '0;
                        r_rd_pend   <= 1'b0;
                        r_stg_valid <= 1'b0;
                        if (dma_op <= 3'd4) begin
                            r_state <= c_st_rd;
                        end else if (dma_op == 3'd5) begin
                            r_state <= c_st_wr;
                        end else begin
                            r_state  <= c_st_done;
                            r_err_op <= 1'b1;
                        end
                    end
                end
                c_st_rd: begin
                    if (w_rd_gnt) begin
                        r_issued <= r_issued + c_one;
                    end
                    r_outst <= r_outst + {3'b000, w_rd_gnt} - {3'b000, w_rd_rcv};
                    if (w_rd_rcv) begin
                        r_received <= r_received + c_one;
                        if (r_op == 3'd0) begin
                            if (r_received == '0) begin
                                r_inf_conv[31:0] <= mem_rdata[31:0];
                            end else begin
                                r_inf_conv[63:32] <= mem_rdata[31:0];
                            end
                        end
                        if ((r_received + c_one) == r_len) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_wr: begin
                    if (w_buf_re) begin
                        r_k <= r_k + c_one;
                    end
                    r_rd_pend   <= w_buf_re;
                    r_stg_valid <= w_have && !w_wr_fire;
                    if (r_rd_pend && !w_wr_fire) begin
                        r_stg_data <= buf_rdata;
                    end
                    if (w_wr_fire) begin
                        r_sent <= r_sent + c_one;
                        if ((r_sent + c_one) == r_len) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign f_dma      = (r_state == c_st_done);
    assign busy       = (r_state != c_st_idle);
    assign inf_conv   = r_inf_conv;
    assign tag_info1  = r_tag1;
    assign tag_info2  = r_tag2;
    assign err_op     = r_err_op;
    assign err_busy   = r_err_busy;
    assign mem_rd_req = w_rd_req;
    assign mem_wr_req = w_wr_req;
    assign mem_addr   = w_in_rd ? (r_start + {{c_pad{1'b0}}, r_issued}) :
                        w_in_wr ? (r_start + {{c_pad{1'b0}}, r_sent})   : 32'h0;
    assign mem_wdata  = w_wr_req ? w_wdata : '0;
    assign buf_sel    = r_op;
    assign buf_we     = w_rd_rcv && (r_op != 3'd0);
    assign buf_re     = w_buf_re;
    assign buf_addr   = w_in_rd ? r_received[BUF_AW-1:0] :
                        w_in_wr ? r_k[BUF_AW-1:0]        : '0;
    assign buf_wdata  = buf_we ? mem_rdata : '0;

`ifdef DMA_PERF_CNT_EN
    logic [63:0] r_perf_rd;
    logic [63:0] r_perf_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_rd <= '0;
            r_perf_wr <= '0;
        end else begin
            if (w_in_rd) r_perf_rd <= r_perf_rd + 64'd1;
            if (w_in_wr) r_perf_wr <= r_perf_wr + 64'd1;
        end
    end

    assign perf_rd_cycles = r_perf_rd;
    assign perf_wr_cycles = r_perf_wr;
`else
    assign perf_rd_cycles = 64'd0;
    assign perf_wr_cycles = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_responder
// Purpose  : Directed self-checking bench for dma_responder. A memory model
//            grants requests (always / never / alternating) and returns read
//            data in order after a programmable latency; a buffer model
//            answers buffer reads one cycle later. A negedge monitor logs
//            handshakes which each scenario task then compares against
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_responder;

    localparam int          DATA_W   = 32;
    localparam int          BUF_AW   = 12;
    localparam logic [31:0] FMI_BASE = 32'h0001_0000;
    localparam logic [31:0] KPW_BASE = 32'h0020_0000;
    localparam logic [31:0] FMO_BASE = 32'h0040_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_dma;
    logic [2:0]        dma_op;
    logic [31:0]       dma_info1, dma_info2, dma_mem_info1, dma_mem_info2;
    logic              f_dma, busy, err_op, err_busy;
    logic [63:0]       inf_conv, perf_rd_cycles, perf_wr_cycles;
    logic [31:0]       tag_info1, tag_info2;
    logic              mem_rd_req, mem_wr_req, mem_gnt, mem_rvalid;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, buf_wdata, buf_rdata;
    logic [2:0]        buf_sel;
    logic              buf_we, buf_re;
    logic [BUF_AW-1:0] buf_addr;

    dma_responder #(
        .DATA_W(DATA_W), .BUF_AW(BUF_AW), .MAX_OUTST(4),
        .INF_BASE(32'h0000_0000), .FMI_BASE(FMI_BASE), .KEX_BASE(32'h0010_0000),
        .KPW_BASE(KPW_BASE), .KDW_BASE(32'h0030_0000), .FMO_BASE(FMO_BASE),
        .LEN_FMI(256), .LEN_KEX(64), .LEN_KPW(64), .LEN_KDW(72), .LEN_FMO(128)
    ) dut (
        .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
        .dma_info1(dma_info1), .dma_info2(dma_info2),
        .dma_mem_info1(dma_mem_info1), .dma_mem_info2(dma_mem_info2),
        .f_dma(f_dma), .busy(busy), .inf_conv(inf_conv),
        .tag_info1(tag_info1), .tag_info2(tag_info2),
        .err_op(err_op), .err_busy(err_busy),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .buf_sel(buf_sel), .buf_we(buf_we), .buf_re(buf_re),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .perf_rd_cycles(perf_rd_cycles), .perf_wr_cycles(perf_wr_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // memory / buffer model state
    typedef struct { int due; logic [31:0] addr; } resp_t;
    resp_t             resp_q[$];
    int                cyc_p    = 0;
    int                gnt_mode = 0;   // 0 never, 1 always, 2 alternating
    int                lat      = 1;
    logic              pend_re  = 1'b0;
    logic [BUF_AW-1:0] pend_addr = '0;

    // monitor logs
    int          rd_hs, we_cnt, wr_cnt, fdma_cnt, both_cnt, req_cnt;
    int          mon_outst, max_outst, wr_first, wr_last;
    logic [31:0] rd_addr_log [0:1023];
    logic [31:0] we_addr_log [0:1023];
    logic [31:0] we_data_log [0:1023];
    logic [31:0] wr_addr_log [0:1023];
    logic [31:0] wr_data_log [0:1023];

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0302_1040;
        if (a == 32'h1) return 32'h0000_0001;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] buf_word(input logic [BUF_AW-1:0] a);
        return 32'hC300_0000 + {20'h0, a} * 32'd3;
    endfunction

    // memory + buffer responder, drives inputs 1 time unit after the edge
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; buf_rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc_p++;
            case (gnt_mode)
                0:       mem_gnt = 1'b0;
                1:       mem_gnt = 1'b1;
                default: mem_gnt = cyc_p[0];
            endcase
            if (resp_q.size() > 0 && resp_q[0].due <= cyc_p) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_word(resp_q[0].addr);
                void'(resp_q.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0BAD_0BAD;
            end
            buf_rdata = pend_re ? buf_word(pend_addr) : 32'hDEAD_BEEF;
        end
    end

    // negedge monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_outst > max_outst) max_outst = mon_outst;
            mon_outst = mon_outst + ((mem_rd_req && mem_gnt) ? 1 : 0) - (mem_rvalid ? 1 : 0);
            if (mem_rd_req && mem_gnt) begin
                if (rd_hs < 1024) rd_addr_log[rd_hs] = mem_addr;
                resp_q.push_back('{cyc_p + lat, mem_addr});
                rd_hs++;
            end
            if (buf_we) begin
                if (we_cnt < 1024) begin
                    we_addr_log[we_cnt] = {20'h0, buf_addr};
                    we_data_log[we_cnt] = buf_wdata;
                end
                we_cnt++;
            end
            if (mem_wr_req && mem_gnt) begin
                if (wr_cnt < 1024) begin
                    wr_addr_log[wr_cnt] = mem_addr;
                    wr_data_log[wr_cnt] = mem_wdata;
                end
                if (wr_cnt == 0) wr_first = cyc_p;
                wr_last = cyc_p;
                wr_cnt++;
            end
            if (f_dma) fdma_cnt++;
            if (mem_rd_req && mem_wr_req) both_cnt++;
            if (mem_rd_req || mem_wr_req) req_cnt++;
            pend_re   = buf_re;
            pend_addr = buf_addr;
        end
    end

    task automatic clear_mon();
        rd_hs = 0; we_cnt = 0; wr_cnt = 0; fdma_cnt = 0; both_cnt = 0; req_cnt = 0;
        mon_outst = 0; max_outst = 0; wr_first = 0; wr_last = 0;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 200 && resp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk); #2;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] i1, input logic [31:0] i2,
                            input logic [31:0] m1, input logic [31:0] m2);
        @(posedge clk); #2;
        s_dma = 1'b1; dma_op = op; dma_info1 = i1; dma_info2 = i2;
        dma_mem_info1 = m1; dma_mem_info2 = m2;
        @(posedge clk); #2;
        s_dma = 1'b0;
    endtask

    task automatic wait_fdma(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (fdma_cnt > 0) begin ok = 1'b1; break; end
        end
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (f_dma !== 1'b0) begin n_fail++; $display("FAIL reset_f_dma: got %0b want 0", f_dma); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (inf_conv !== 64'h0) begin n_fail++; $display("FAIL reset_inf_conv: got %h want 0", inf_conv); end
        n_checks++; if ({err_op, err_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {err_op, err_busy}); end
        n_checks++; if ({mem_rd_req, mem_wr_req, buf_we, buf_re} !== 4'b0000) begin n_fail++; $display("FAIL reset_req: got %b want 0000", {mem_rd_req, mem_wr_req, buf_we, buf_re}); end
        n_checks++; if ({perf_rd_cycles, perf_wr_cycles} !== 128'h0) begin n_fail++; $display("FAIL reset_perf: got %h/%h want 0", perf_rd_cycles, perf_wr_cycles); end
        n_checks++; if ({tag_info1, tag_info2, mem_addr} !== 96'h0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h want 0", tag_info1, tag_info2, mem_addr); end
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic test_inf_load();
        bit ok;
        gnt_mode = 1; lat = 1;
        wait_quiet(); clear_mon();
        send_cmd(3'd0, 32'h1111_0000, 32'h2222_0000, 32'h0000_0005, 32'h0000_0007);
        wait_fdma(100, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inf_timeout: got no f_dma want f_dma"); end
        n_checks++; if (inf_conv !== 64'h0000_0001_0302_1040) begin n_fail++; $display("FAIL inf_conv: got %h want 0000000103021040", inf_conv); end
        n_checks++; if (fdma_cnt !== 1) begin n_fail++; $display("FAIL inf_fdma_count: got %0d want 1", fdma_cnt); end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL inf_buf_we: got %0d writes want 0", we_cnt); end
        n_checks++; if (rd_hs !== 2) begin n_fail++; $display("FAIL inf_reads: got %0d want 2", rd_hs); end
        n_checks++; if ({rd_addr_log[0], rd_addr_log[1]} !== {32'h0, 32'h1}) begin n_fail++; $display("FAIL inf_addr: got %h %h want 0 1", rd_addr_log[0], rd_addr_log[1]); end
        n_checks++; if ({tag_info1, tag_info2} !== {32'h1111_0000, 32'h2222_0000}) begin n_fail++; $display("FAIL inf_tags: got %h %h want 11110000 22220000", tag_info1, tag_info2); end
    endtask

    task automatic test_fmi_load();
        bit ok;
        int bad_ra, bad_wa, bad_wd;
        gnt_mode = 1; lat = 5;
        wait_quiet(); clear_mon();
        send_cmd(3'd1, 32'hA, 32'hB, 32'd16, 32'd32);
        wait_fdma(2000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fmi_timeout: got no f_dma want f_dma"); end
        n_checks++; if (rd_addr_log[0] !== 32'h0001_0030) begin n_fail++; $display("FAIL fmi_first_addr: got %h want 00010030", rd_addr_log[0]); end
        n_checks++; if (max_outst !== 4) begin n_fail++; $display("FAIL fmi_max_outstanding: got %0d want 4", max_outst); end
        n_checks++; if (rd_hs !== 256) begin n_fail++; $display("FAIL fmi_reads: got %0d want 256", rd_hs); end
        n_checks++; if (we_cnt !== 256) begin n_fail++; $display("FAIL fmi_writes: got %0d want 256", we_cnt); end
        bad_ra = 0; bad_wa = 0; bad_wd = 0;
        for (int i = 0; i < 256; i++) begin
            if (rd_addr_log[i] !== FMI_BASE + 32'h30 + i) bad_ra++;
            if (we_addr_log[i] !== i) bad_wa++;
            if (we_data_log[i] !== rd_word(FMI_BASE + 32'h30 + i)) bad_wd++;
        end
        n_checks++; if (bad_ra !== 0) begin n_fail++; $display("FAIL fmi_addr_seq: got %0d wrong addresses want 0", bad_ra); end
        n_checks++; if (bad_wa !== 0) begin n_fail++; $display("FAIL fmi_buf_addr: got %0d wrong buffer addresses want 0", bad_wa); end
        n_checks++; if (bad_wd !== 0) begin n_fail++; $display("FAIL fmi_buf_data: got %0d wrong words want 0", bad_wd); end
        n_checks++; if (fdma_cnt !== 1) begin n_fail++; $display("FAIL fmi_fdma_count: got %0d want 1", fdma_cnt); end
        n_checks++; if (buf_sel !== 3'd1) begin n_fail++; $display("FAIL fmi_buf_sel: got %0d want 1", buf_sel); end
    endtask

    task automatic test_fmo_store(input int mode, input logic [31:0] m1, input logic [31:0] m2);
        bit ok;
        int bad_a, bad_d;
        gnt_mode = mode; lat = 1;
        wait_quiet(); clear_mon();
        send_cmd(3'd5, 32'h5, 32'h6, m1, m2);
        wait_fdma(1000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fmo%0d_timeout: got no f_dma want f_dma", mode); end
        n_checks++; if (wr_cnt !== 128) begin n_fail++; $display("FAIL fmo%0d_writes: got %0d want 128", mode, wr_cnt); end
        bad_a = 0; bad_d = 0;
        for (int i = 0; i < 128; i++) begin
            if (wr_addr_log[i] !== FMO_BASE + m1 + m2 + i) bad_a++;
            if (wr_data_log[i] !== buf_word(i[BUF_AW-1:0])) bad_d++;
        end
        n_checks++; if (bad_a !== 0) begin n_fail++; $display("FAIL fmo%0d_addr: got %0d wrong addresses want 0", mode, bad_a); end
        n_checks++; if (bad_d !== 0) begin n_fail++; $display("FAIL fmo%0d_data: got %0d wrong words want 0", mode, bad_d); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL fmo%0d_rd_wr_overlap: got %0d cycles want 0", mode, both_cnt); end
        n_checks++; if (fdma_cnt !== 1) begin n_fail++; $display("FAIL fmo%0d_fdma_count: got %0d want 1", mode, fdma_cnt); end
        if (mode == 1) begin
            n_checks++; if (wr_last - wr_first !== 127) begin n_fail++; $display("FAIL fmo_back_to_back: got span %0d want 127", wr_last - wr_first); end
        end else begin
            n_checks++; if (rd_hs !== 0) begin n_fail++; $display("FAIL fmo_no_reads: got %0d want 0", rd_hs); end
        end
    endtask

    task automatic test_busy_cmd();
        bit ok;
        gnt_mode = 1; lat = 3;
        wait_quiet(); clear_mon();
        send_cmd(3'd3, 32'h0000_3333, 32'h0000_4444, 32'h0000_0100, 32'h0000_0002);
        repeat (10) @(posedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_during: got %0b want 1", busy); end
        send_cmd(3'd2, 32'h0000_BBBB, 32'h0000_CCCC, 32'h0, 32'h0);
        wait_fdma(1000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_timeout: got no f_dma want f_dma"); end
        n_checks++; if (err_busy !== 1'b1) begin n_fail++; $display("FAIL busy_err_busy: got %0b want 1", err_busy); end
        n_checks++; if (fdma_cnt !== 1) begin n_fail++; $display("FAIL busy_fdma_count: got %0d want 1", fdma_cnt); end
        n_checks++; if (rd_hs !== 64 || we_cnt !== 64) begin n_fail++; $display("FAIL busy_words: got %0d reads %0d writes want 64 64", rd_hs, we_cnt); end
        n_checks++; if (rd_addr_log[0] !== KPW_BASE + 32'h102) begin n_fail++; $display("FAIL busy_first_addr: got %h want 00200102", rd_addr_log[0]); end
        n_checks++; if ({buf_sel, tag_info1} !== {3'd3, 32'h0000_3333}) begin n_fail++; $display("FAIL busy_latched: got sel %0d tag %h want 3 00003333", buf_sel, tag_info1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %0b want 0", busy); end
    endtask

    task automatic test_illegal_op();
        wait_quiet(); clear_mon();
        gnt_mode = 1;
        @(posedge clk); #2;
        s_dma = 1'b1; dma_op = 3'd7;
        @(negedge clk);
        n_checks++; if (f_dma !== 1'b0) begin n_fail++; $display("FAIL illegal_fdma_c0: got %0b want 0", f_dma); end
        @(posedge clk); #2;
        s_dma = 1'b0;
        @(negedge clk);
        n_checks++; if (f_dma !== 1'b1) begin n_fail++; $display("FAIL illegal_fdma_c1: got %0b want 1", f_dma); end
        n_checks++; if (err_op !== 1'b1) begin n_fail++; $display("FAIL illegal_err_op: got %0b want 1", err_op); end
        @(negedge clk);
        n_checks++; if ({f_dma, busy} !== 2'b00) begin n_fail++; $display("FAIL illegal_c2: got f_dma %0b busy %0b want 0 0", f_dma, busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL illegal_no_traffic: got %0d request cycles want 0", req_cnt); end
        n_checks++; if ({err_op, err_busy} !== 2'b11) begin n_fail++; $display("FAIL illegal_sticky: got %b want 11", {err_op, err_busy}); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        gnt_mode = 1; lat = 8;
        wait_quiet(); clear_mon();
        send_cmd(3'd1, 32'h77, 32'h88, 32'h0, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (rd_hs >= 10) begin hit = 1'b1; break; end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_grants: got %0d grants want 10", rd_hs); end
        rst = 1'b1;
        @(posedge clk); #2;
        clear_mon();
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({perf_rd_cycles, perf_wr_cycles} !== 128'h0) begin n_fail++; $display("FAIL rstmid_perf: got %h/%h want 0", perf_rd_cycles, perf_wr_cycles); end
        n_checks++; if (inf_conv !== 64'h0) begin n_fail++; $display("FAIL rstmid_inf_conv: got %h want 0", inf_conv); end
        repeat (20) @(negedge clk);
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rstmid_buf_we: got %0d writes want 0", we_cnt); end
        n_checks++; if (fdma_cnt !== 0) begin n_fail++; $display("FAIL rstmid_fdma: got %0d want 0", fdma_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        n_checks++; if (req_cnt !== 0) begin n_fail++; $display("FAIL rstmid_requests: got %0d want 0", req_cnt); end
        n_checks++; if ({err_op, err_busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_err: got %b want 00", {err_op, err_busy}); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_dma = 1'b0; dma_op = 3'd0;
        dma_info1 = '0; dma_info2 = '0; dma_mem_info1 = '0; dma_mem_info2 = '0;
        clear_mon();
        test_reset();
        test_inf_load();
        test_fmi_load();
        test_fmo_store(1, 32'h0, 32'h0);
        test_fmo_store(2, 32'h100, 32'h4);
        test_busy_cmd();
        test_illegal_op();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_responder.md
Name: dma_responder

Overview:
- Responder end of the controller-to-DMA command handshake (s_dma / dma_op / dma_info* / dma_mem_info* -> f_dma) used by the inverted-residual-block accelerator.
- Accepts one command at a time and moves data in one of two directions:
  - loads: external memory -> on-chip buffers (layer info word, FMI tile, KEX/KPW/KDW kernels);
  - store: output buffer -> external memory (FMO tile).
- Signals completion to the controller with a single-cycle f_dma pulse.

Parameters:
- DATA_W, 32, memory/buffer word width
- BUF_AW, 12, on-chip buffer address width
- MAX_OUTST, 4, max outstanding external read requests (1..15)
- INF_BASE, 32'h0000_0000, word address of the 64-bit layer info
- FMI_BASE / KEX_BASE / KPW_BASE / KDW_BASE / FMO_BASE, 32'h0001_0000 / 32'h0010_0000 / 32'h0020_0000 / 32'h0030_0000 / 32'h0040_0000, region base addresses
- LEN_FMI / LEN_KEX / LEN_KPW / LEN_KDW / LEN_FMO, 256 / 64 / 64 / 72 / 128, burst length in words (1..2^BUF_AW)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_dma  in  1  command strobe, single cycle
- dma_op  in  3  0=INF 1=FMI 2=KEX 3=KPW 4=KDW 5=FMO
- dma_info1, dma_info2  in  32  loop tags
- dma_mem_info1, dma_mem_info2  in  32  address offsets
- f_dma  out  1  done pulse
- busy  out  1  state != IDLE
- inf_conv  out  64  layer info word
- tag_info1, tag_info2  out  32  latched dma_info1/2
- err_op, err_busy  out  1  sticky error flags
- mem_rd_req, mem_wr_req  out  1  external requests
- mem_addr  out  32  request address
- mem_wdata  out  DATA_W  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid (in order)
- mem_rdata  in  DATA_W  read data
- buf_sel  out  3  target buffer = latched op
- buf_we  out  1  buffer write enable
- buf_re  out  1  buffer read enable
- buf_addr  out  BUF_AW  buffer address
- buf_wdata  out  DATA_W  buffer write data
- buf_rdata  in  DATA_W  buffer read data, valid 1 cycle after buf_re
- perf_rd_cycles, perf_wr_cycles  out  64  busy-cycle counters (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transfer aborts it: no f_dma, and late mem_rvalid is ignored in IDLE.
- Acceptance: s_dma is sampled only in IDLE. In the acceptance cycle the block latches op, tag_info1/2 and start address = BASE_op + dma_mem_info1 + dma_mem_info2 (mod 2^32). For op 0 the start address is INF_BASE and the offsets are ignored.
- Command while busy: s_dma is ignored and err_busy is set (sticky until rst).
- Illegal op 6/7: go to DONE; err_op set (sticky); no memory traffic.
- States:
  - IDLE -> RD_BURST (ops 0-4)
  - IDLE -> WR_BURST (op 5)
  - IDLE -> DONE (illegal op)
  - RD_BURST / WR_BURST -> DONE when complete
  - DONE -> IDLE after one cycle; f_dma = 1 only in DONE.
- Burst length: N = 2 for op 0, otherwise LEN_op.
- RD_BURST:
  - mem_rd_req is high while issued < N and outstanding < MAX_OUTST.
  - mem_addr = start + issued. On mem_gnt: issued++, outstanding++.
  - Each mem_rvalid: outstanding--, received++.
  - Ops 1-4: buf_we = 1, buf_addr = received (pre-increment value), buf_wdata = mem_rdata, same cycle.
  - Op 0: first word goes to inf_conv[31:0], second to inf_conv[63:32]; buf_we stays 0.
  - Grant and rvalid in the same cycle: both counters update and outstanding is unchanged.
  - Exit to DONE in the cycle after received reaches N.
- WR_BURST:
  - Buffer read issues buf_re with buf_addr = k. The next cycle, buf_rdata loads a 1-entry staging register marked valid.
  - mem_wr_req = staging valid; mem_wdata = staging; mem_addr = start + sent.
  - On mem_gnt: sent++; staging may be refilled in the same cycle (buf_re asserted speculatively when staging is empty or being granted, and k < N).
  - Back-to-back grants therefore sustain 1 word/cycle.
  - Exit to DONE in the cycle after sent reaches N.
- inf_conv holds its value until the next op 0 or rst.
- mem_rd_req and mem_wr_req are never high together.

Optional Feature:
- Macro: DMA_PERF_CNT_EN.
- Defined:
  - perf_rd_cycles increments every cycle in RD_BURST.
  - perf_wr_cycles increments every cycle in WR_BURST.
  - Both are 64-bit, wrap at 2^64, cleared only by rst.
- Undefined: both outputs are constant 0 and no counter flops exist.

Test Plan:
- op 0, memory returns 32'h0302_1040 then 32'h0000_0001, zero-wait grant -> inf_conv = 64'h0000_0001_0302_1040; f_dma single pulse; buf_we never high.
- op 1, mem_info1 = 16, mem_info2 = 32, LEN_FMI = 256, rvalid latency 5, MAX_OUTST = 4 -> first mem_addr = 32'h0001_0030; never more than 4 outstanding; buf writes at addr 0..255 in order; one f_dma.
- op 5, LEN_FMO = 128, mem_gnt always high -> 128 consecutive write cycles with addresses FMO_BASE..+127 and data = buffer[0..127]. Repeat with mem_gnt toggling every other cycle -> no data lost or duplicated.
- s_dma with op 2 during an op 3 transfer -> err_busy = 1; the current transfer completes normally; exactly one f_dma.
- op 7 -> f_dma 2 cycles after s_dma, err_op = 1, no mem requests.
- rst mid op 1 after 10 grants, then pending rvalids arrive -> no buf_we, no f_dma, busy = 0. With DMA_PERF_CNT_EN: counters read 0 after rst.
